// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity engine.
package serial_parity_pkg;

    typedef enum logic [1:0] {
        DATA    = 2'd0,
        GEN_PAR = 2'd1,
        CHK_PAR = 2'd2
    } state_t;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_unit_if.sv
// Bit-serial link bundle between the parity engine and its source/sink.
// slave: the parity engine. master: the source feeding bits in and the sink
// consuming the forwarded stream and frame status.
interface serial_parity_unit_if #(
    parameter int ERR_W = 8
);
    logic             mode;
    logic             odd_sel;
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             out_valid;
    logic             out_bit;
    logic             out_par;
    logic             frame_done;
    logic             par_err;
    logic [ERR_W-1:0] err_cnt;

    modport slave (
        input  mode, odd_sel, in_valid, in_bit,
        output in_ready, out_valid, out_bit, out_par, frame_done, par_err, err_cnt
    );

    modport master (
        output mode, odd_sel, in_valid, in_bit,
        input  in_ready, out_valid, out_bit, out_par, frame_done, par_err, err_cnt
    );
endinterface

// File: rtl/serial_parity_unit.sv
// Serial parity engine: forwards FRAME_LEN data bits and either appends a
// generated parity bit (generate mode) or consumes and checks a received
// parity bit (check mode), counting errored frames with saturation.
//
// state   | meaning
// --------+-------------------------------------------------------------
// DATA    | accepting and forwarding data bits, accumulating parity
// GEN_PAR | one-cycle bubble that emits the generated parity bit
// CHK_PAR | waiting for the received parity bit, which is not forwarded
module serial_parity_unit
    import serial_parity_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int ERR_W     = 8
) (
    input  logic                       clk,
    input  logic                       arst,
    serial_parity_unit_if.slave        bus
);

    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic              mode_q, mode_d;
    logic              odd_q, odd_d;
    logic              rdy_en_q;

    logic              out_valid_q, out_valid_d;
    logic              out_bit_q, out_bit_d;
    logic              out_par_q, out_par_d;
    logic              frame_done_q, frame_done_d;
    logic              par_err_q, par_err_d;
    logic [ERR_W-1:0]  err_q, err_d;

    logic              in_ready_w;
    logic              accept;

    // in_ready stays low during reset and comes up on the first edge after release
    assign in_ready_w = rdy_en_q & (state_q != GEN_PAR);
    assign accept     = bus.in_valid & in_ready_w;

    // State register, frame bookkeeping and registered outputs
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= DATA;
            cnt_q        <= '0;
            acc_q        <= 1'b0;
            mode_q       <= MODE_GEN;
            odd_q        <= PAR_EVEN;
            rdy_en_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_bit_q    <= 1'b0;
            out_par_q    <= 1'b0;
            frame_done_q <= 1'b0;
            par_err_q    <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            mode_q       <= mode_d;
            odd_q        <= odd_d;
            rdy_en_q     <= 1'b1;
            out_valid_q  <= out_valid_d;
            out_bit_q    <= out_bit_d;
            out_par_q    <= out_par_d;
            frame_done_q <= frame_done_d;
            par_err_q    <= par_err_d;
            err_q        <= err_d;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        mode_d       = mode_q;
        odd_d        = odd_q;
        out_valid_d  = 1'b0;
        out_bit_d    = out_bit_q;
        out_par_d    = 1'b0;
        frame_done_d = 1'b0;
        par_err_d    = 1'b0;
        err_d        = err_q;

        case (state_q)
            DATA: begin
                if (accept) begin
                    // mode/parity are frozen by the first bit of each frame
                    if (cnt_q == '0) begin
                        mode_d = bus.mode;
                        odd_d  = bus.odd_sel;
                    end
                    acc_d       = acc_q ^ bus.in_bit;
                    out_valid_d = 1'b1;
                    out_bit_d   = bus.in_bit;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = (mode_d == MODE_CHK) ? CHK_PAR : GEN_PAR;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            GEN_PAR: begin
                out_valid_d  = 1'b1;
                out_bit_d    = acc_q ^ odd_q;
                out_par_d    = 1'b1;
                frame_done_d = 1'b1;
                acc_d        = 1'b0;
                cnt_d        = '0;
                state_d      = DATA;
            end

            CHK_PAR: begin
                if (accept) begin
                    // Error when the ones count over data+parity disagrees
                    // with the selected sense (odd for odd_q=1, even for 0).
                    frame_done_d = 1'b1;
                    par_err_d    = acc_q ^ bus.in_bit ^ odd_q;
                    if (par_err_d && (err_q != '1)) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end

            default: begin
                state_d = DATA;
                cnt_d   = '0;
                acc_d   = 1'b0;
            end
        endcase
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_bit    = out_bit_q;
    assign bus.out_par    = out_par_q;
    assign bus.frame_done = frame_done_q;
    assign bus.par_err    = par_err_q;
    assign bus.err_cnt    = err_q;

endmodule

// File: tb/tb_serial_parity_unit.sv
// Scoreboard bench for serial_parity_unit: a cycle model predicts every
// output event one edge ahead; a second instance with a 2-bit error counter
// shares the stimulus to exercise saturation.
module tb_serial_parity_unit;
    import serial_parity_pkg::*;

    localparam int FL = 8;

    logic tb_clk;
    logic arst;

    serial_parity_unit_if #(.ERR_W(8)) bus ();
    serial_parity_unit_if #(.ERR_W(2)) bus2 ();

    assign bus2.mode     = bus.mode;
    assign bus2.odd_sel  = bus.odd_sel;
    assign bus2.in_valid = bus.in_valid;
    assign bus2.in_bit   = bus.in_bit;

    serial_parity_unit #(.FRAME_LEN(FL), .ERR_W(8)) dut (
        .clk  (tb_clk),
        .arst (arst),
        .bus  (bus)
    );

    serial_parity_unit #(.FRAME_LEN(FL), .ERR_W(2)) dut2 (
        .clk  (tb_clk),
        .arst (arst),
        .bus  (bus2)
    );

    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    typedef struct {
        logic       ov;
        logic       ob;
        logic       op;
        logic       fd;
        logic       pe;
        logic [7:0] ec;
        logic [1:0] ec2;
    } exp_t;

    exp_t q[$];

    int n_vec  = 0;
    int n_miss = 0;

    // model state: 0 DATA, 1 GEN_PAR, 2 CHK_PAR
    int         ms;
    int         m_cnt;
    logic       m_acc, m_mode, m_odd, m_rdy;
    logic [7:0] m_ec;
    logic [1:0] m_ec2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ms = 0; m_cnt = 0; m_acc = 0; m_mode = 0; m_odd = 0; m_rdy = 0;
        m_ec = 0; m_ec2 = 0;
        q.delete();
    endtask

    // One cycle, entered and left at a negedge: check the outputs of the
    // previous edge, drive inputs, advance the model.
    task automatic step(input logic v, input logic b, input logic m, input logic o,
                        output logic took);
        exp_t e;
        logic rdy;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_valid", bus.out_valid, e.ov);
            if (e.ov) begin
                chk("out_bit", bus.out_bit, e.ob);
                chk("out_par", bus.out_par, e.op);
            end
            chk("frame_done", bus.frame_done, e.fd);
            if (e.fd) begin
                chk("par_err", bus.par_err, e.pe);
                chk("err_cnt", bus.err_cnt, e.ec);
                chk("err_cnt_w2", bus2.err_cnt, e.ec2);
            end
        end else begin
            chk("idle_out_valid", bus.out_valid, 0);
            chk("idle_out_par", bus.out_par, 0);
            chk("idle_frame_done", bus.frame_done, 0);
        end
        rdy = m_rdy && (ms != 1);
        chk("in_ready", bus.in_ready, rdy);
        chk("in_ready_w2", bus2.in_ready, rdy);

        bus.in_valid = v;
        bus.in_bit   = b;
        bus.mode     = m;
        bus.odd_sel  = o;
        took = v && rdy;

        if (ms == 1) begin
            e = '{ov: 1, ob: m_acc ^ m_odd, op: 1, fd: 1, pe: 0, ec: m_ec, ec2: m_ec2};
            q.push_back(e);
            m_acc = 0;
            ms = 0;
        end else if (took && ms == 0) begin
            if (m_cnt == 0) begin
                m_mode = m;
                m_odd  = o;
            end
            m_acc = m_acc ^ b;
            e = '{ov: 1, ob: b, op: 0, fd: 0, pe: 0, ec: m_ec, ec2: m_ec2};
            q.push_back(e);
            if (m_cnt == FL - 1) begin
                m_cnt = 0;
                ms = m_mode ? 2 : 1;
            end else begin
                m_cnt++;
            end
        end else if (took && ms == 2) begin
            e.pe = m_acc ^ b ^ m_odd;
            if (e.pe) begin
                if (m_ec != 8'hFF) m_ec++;
                if (m_ec2 != 2'd3) m_ec2++;
            end
            e.ov = 0; e.ob = 0; e.op = 0; e.fd = 1; e.ec = m_ec; e.ec2 = m_ec2;
            q.push_back(e);
            m_acc = 0;
            ms = 0;
        end

        @(posedge tb_clk);
        m_rdy = !arst;
        @(negedge tb_clk);
    endtask

    task automatic send_bit(input logic b, input logic m, input logic o, input int gap_pct);
        logic took;
        int   tries;
        if ($urandom_range(99) < gap_pct) begin
            repeat ($urandom_range(1, 3))
                step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), took);
        end
        took  = 0;
        tries = 0;
        while (!took && tries < 4) begin
            step(1'b1, b, m, o, took);
            tries++;
        end
        if (!took) chk("accept_timeout", 0, 1);
    endtask

    // Data sent MSB first; tog flips mode/odd_sel from bit 3 onward.
    task automatic send_frame(input logic [FL-1:0] data, input logic m, input logic o,
                              input logic tog, input logic par, input int gap_pct);
        logic mm, oo;
        for (int i = 0; i < FL; i++) begin
            mm = (tog && i >= 3) ? ~m : m;
            oo = (tog && i >= 3) ? ~o : o;
            send_bit(data[FL-1-i], mm, oo, gap_pct);
        end
        if (ms == 2) send_bit(par, mm, oo, gap_pct);
    endtask

    task automatic idle(input int n);
        logic took;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, took);
    endtask

    task automatic do_reset();
        arst = 1'b1;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_bit", bus.out_bit, 0);
        chk("rst_out_par", bus.out_par, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_par_err", bus.par_err, 0);
        chk("rst_err_cnt", bus.err_cnt, 0);
        chk("rst_err_cnt_w2", bus2.err_cnt, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        @(posedge tb_clk);
        @(negedge tb_clk);
        arst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [FL-1:0] d;
        logic          rm, ro, rp;

        arst         = 1'b1;
        bus.in_valid = 0;
        bus.in_bit   = 0;
        bus.mode     = 0;
        bus.odd_sel  = 0;
        model_reset();
        @(negedge tb_clk);
        do_reset();

        // generate odd / even, back-to-back across the bubble
        send_frame(8'b0000_1100, MODE_GEN, PAR_ODD, 0, 0, 0);
        send_frame(8'b1000_1100, MODE_GEN, PAR_EVEN, 0, 0, 0);
        send_frame(8'b1000_1100, MODE_GEN, PAR_ODD, 0, 0, 0);
        idle(2);

        // check odd: good parity then bad parity
        send_frame(8'b1000_1100, MODE_CHK, PAR_ODD, 0, 1'b0, 0);
        send_frame(8'b1000_1100, MODE_CHK, PAR_ODD, 0, 1'b1, 0);
        idle(2);
        chk("err_after_bad_frame", bus.err_cnt, 1);

        // mode/odd_sel toggled mid-frame
        send_frame(8'b1011_0010, MODE_GEN, PAR_ODD, 1, 0, 0);
        send_frame(8'b0110_0111, MODE_CHK, PAR_EVEN, 1, 1, 0);
        idle(2);

        // random frames with gaps
        for (int f = 0; f < 50; f++) begin
            d  = FL'($urandom);
            rm = 1'($urandom_range(1));
            ro = 1'($urandom_range(1));
            rp = 1'($urandom_range(1));
            send_frame(d, rm, ro, 0, rp, 30);
        end
        idle(3);

        // reset after the 5th data bit, then a clean frame
        for (int i = 0; i < 5; i++) send_bit(1'b1, MODE_GEN, PAR_EVEN, 0);
        do_reset();
        send_frame(8'b1110_0000, MODE_GEN, PAR_EVEN, 0, 0, 0);
        idle(2);

        // counter saturation on the 2-bit instance
        do_reset();
        for (int f = 0; f < 5; f++) send_frame(8'b1100_0000, MODE_CHK, PAR_EVEN, 0, 1'b1, 10);
        idle(2);
        chk("err_sat_w2", bus2.err_cnt, 3);
        chk("err_cnt_w8", bus.err_cnt, 5);

        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
